// File: rtl/hazard_ctrl.sv
// Hazard and interrupt sequencer for the 5-stage MIPS pipeline: steers IF/ID, ID/EX and PC.
// Optional feature: define IRQ_SYNC_EN to pass IRQ through a 2-flop synchronizer.
module hazard_ctrl #(
   parameter int LOADUSE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       EX_MemRd,
   input  logic [4:0] EX_Rt,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic       ID_UsesRt,
   input  logic       ID_Jump,
   input  logic       EX_BranchTaken,
   input  logic       ID_NoIRQ,
   input  logic       IRQ,
   input  logic       Eret,
   output logic [1:0] IF_ID_Src,
   output logic       ID_EX_Stall,
   output logic       PC_Hold,
   output logic [1:0] PC_Src,
   output logic       IRQ_Ack
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] SRC_PASS   = 2'd0;
   localparam logic [1:0] SRC_BUBBLE = 2'd1;
   localparam logic [1:0] SRC_HOLD   = 2'd2;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_TARGET = 2'd1;
   localparam logic [1:0] PC_VECTOR = 2'd2;

   // The LU cycle itself is the first bubble, so the counter covers the rest.
   localparam logic [2:0] CNT_RELOAD = 3'(LOADUSE_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_nxt;
   logic       irq_eff;
   logic       lu;
   logic       stall;
   logic       take;

`ifdef IRQ_SYNC_EN
   logic [1:0] irq_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_sync <= 2'b00;
      end else begin
         irq_sync <= {irq_sync[0], IRQ};
      end
   end

   assign irq_eff = irq_sync[1];
`else
   assign irq_eff = IRQ;
`endif

   assign lu = EX_MemRd && (EX_Rt != 5'd0) &&
               ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

   assign stall = lu || (cnt != 3'd0);

   // A take needs a clean cycle: no redirect from EX and no bubble in flight.
   assign take = (state == ARMED) && irq_eff && ID_NoIRQ &&
                 !EX_BranchTaken && !stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (irq_eff) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (take) begin
               state_nxt = SERVICE;
            end else if (!irq_eff) begin
               state_nxt = IDLE;
            end
         end
         SERVICE: begin
            if (Eret) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      IF_ID_Src   = SRC_PASS;
      ID_EX_Stall = 1'b0;
      PC_Hold     = 1'b0;
      PC_Src      = PC_SEQ;
      IRQ_Ack     = 1'b0;
      cnt_nxt     = cnt;

      if (reset) begin
         IF_ID_Src   = SRC_BUBBLE;
         ID_EX_Stall = 1'b1;
         PC_Hold     = 1'b1;
         cnt_nxt     = 3'd0;
      end else if (EX_BranchTaken) begin
         IF_ID_Src   = SRC_BUBBLE;
         ID_EX_Stall = 1'b1;
         PC_Src      = PC_TARGET;
         cnt_nxt     = 3'd0;
      end else if (take) begin
         IF_ID_Src   = SRC_BUBBLE;
         ID_EX_Stall = 1'b1;
         PC_Src      = PC_VECTOR;
         IRQ_Ack     = 1'b1;
      end else if (stall) begin
         IF_ID_Src   = SRC_HOLD;
         ID_EX_Stall = 1'b1;
         PC_Hold     = 1'b1;
         cnt_nxt     = (cnt == 3'd0) ? CNT_RELOAD : (cnt - 3'd1);
      end else if (ID_Jump) begin
         IF_ID_Src   = SRC_BUBBLE;
         PC_Src      = PC_TARGET;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOADUSE_CYCLES 1 and 3) share stimulus; a queue holds
// the expected output vectors {IF_ID_Src, ID_EX_Stall, PC_Hold, PC_Src, IRQ_Ack}.
module tb_hazard_ctrl;

   localparam logic [6:0] NORM  = 7'b00_0_0_00_0;
   localparam logic [6:0] RST   = 7'b01_1_1_00_0;
   localparam logic [6:0] STALL = 7'b10_1_1_00_0;
   localparam logic [6:0] BR    = 7'b01_1_0_01_0;
   localparam logic [6:0] JMP   = 7'b01_0_0_01_0;
   localparam logic [6:0] TAKE  = 7'b01_1_0_10_1;

`ifdef IRQ_SYNC_EN
   localparam int IRQ_LAT = 3;
`else
   localparam int IRQ_LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       EX_MemRd = 1'b0;
   logic [4:0] EX_Rt = 5'd0;
   logic [4:0] ID_Rs = 5'd0;
   logic [4:0] ID_Rt = 5'd0;
   logic       ID_UsesRt = 1'b0;
   logic       ID_Jump = 1'b0;
   logic       EX_BranchTaken = 1'b0;
   logic       ID_NoIRQ = 1'b0;
   logic       IRQ = 1'b0;
   logic       Eret = 1'b0;

   logic [1:0] if_id_src_1, if_id_src_3;
   logic       id_ex_stall_1, id_ex_stall_3;
   logic       pc_hold_1, pc_hold_3;
   logic [1:0] pc_src_1, pc_src_3;
   logic       irq_ack_1, irq_ack_3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [6:0] exp1;
      logic [6:0] exp3;
   } sb_item_t;

   sb_item_t sb[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.LOADUSE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .EX_MemRd(EX_MemRd), .EX_Rt(EX_Rt),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
      .EX_BranchTaken(EX_BranchTaken), .ID_NoIRQ(ID_NoIRQ), .IRQ(IRQ), .Eret(Eret),
      .IF_ID_Src(if_id_src_1), .ID_EX_Stall(id_ex_stall_1), .PC_Hold(pc_hold_1),
      .PC_Src(pc_src_1), .IRQ_Ack(irq_ack_1)
   );

   hazard_ctrl #(.LOADUSE_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .EX_MemRd(EX_MemRd), .EX_Rt(EX_Rt),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
      .EX_BranchTaken(EX_BranchTaken), .ID_NoIRQ(ID_NoIRQ), .IRQ(IRQ), .Eret(Eret),
      .IF_ID_Src(if_id_src_3), .ID_EX_Stall(id_ex_stall_3), .PC_Hold(pc_hold_3),
      .PC_Src(pc_src_3), .IRQ_Ack(irq_ack_3)
   );

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Outputs are combinational from state plus inputs; sample mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         sb_item_t it;
         it = sb.pop_front();
         chk({it.tag, "/L1"},
             {if_id_src_1, id_ex_stall_1, pc_hold_1, pc_src_1, irq_ack_1}, it.exp1);
         chk({it.tag, "/L3"},
             {if_id_src_3, id_ex_stall_3, pc_hold_3, pc_src_3, irq_ack_3}, it.exp3);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      reset          = 1'b0;
      EX_MemRd       = 1'b0;
      EX_Rt          = 5'd0;
      ID_Rs          = 5'd0;
      ID_Rt          = 5'd0;
      ID_UsesRt      = 1'b0;
      ID_Jump        = 1'b0;
      EX_BranchTaken = 1'b0;
      ID_NoIRQ       = 1'b0;
      IRQ            = 1'b0;
      Eret           = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [6:0] e1, input logic [6:0] e3);
      sb_item_t it;
      it.tag  = tag;
      it.exp1 = e1;
      it.exp3 = e3;
      sb.push_back(it);
   endtask

   task automatic load_use_r5();
      EX_MemRd = 1'b1;
      EX_Rt    = 5'd5;
      ID_Rs    = 5'd5;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         next_cycle(); reset = 1'b1; expect_out("reset", RST, RST);
      end
      next_cycle(); expect_out("idle", NORM, NORM);

      // load-use on Rs
      next_cycle(); load_use_r5(); expect_out("lu_rs", STALL, STALL);
      next_cycle(); expect_out("lu_rs_c2", NORM, STALL);
      next_cycle(); expect_out("lu_rs_c3", NORM, STALL);
      next_cycle(); expect_out("lu_rs_end", NORM, NORM);

      // r0 destination never stalls; Rt only counts when used
      next_cycle(); EX_MemRd = 1'b1; ID_UsesRt = 1'b1; expect_out("lu_r0", NORM, NORM);
      next_cycle(); EX_MemRd = 1'b1; EX_Rt = 5'd7; ID_Rs = 5'd3; ID_Rt = 5'd7;
      expect_out("rt_unused", NORM, NORM);
      next_cycle(); EX_MemRd = 1'b1; EX_Rt = 5'd7; ID_Rs = 5'd3; ID_Rt = 5'd7; ID_UsesRt = 1'b1;
      expect_out("lu_rt", STALL, STALL);
      next_cycle(); expect_out("lu_rt_c2", NORM, STALL);
      next_cycle(); expect_out("lu_rt_c3", NORM, STALL);
      next_cycle(); expect_out("lu_rt_end", NORM, NORM);

      // branch on second stall cycle
      next_cycle(); load_use_r5(); expect_out("br_lu", STALL, STALL);
      next_cycle(); EX_BranchTaken = 1'b1; expect_out("br_mid_stall", BR, BR);
      next_cycle(); expect_out("br_after", NORM, NORM);

      // branch and load-use in the same cycle
      next_cycle(); load_use_r5(); EX_BranchTaken = 1'b1; expect_out("br_with_lu", BR, BR);
      next_cycle(); expect_out("br_with_lu_after", NORM, NORM);

      // jump, and jump suppressed by a stall
      next_cycle(); ID_Jump = 1'b1; expect_out("jump", JMP, JMP);
      next_cycle(); ID_Jump = 1'b1; load_use_r5(); expect_out("jump_lu", STALL, STALL);
      next_cycle(); expect_out("jump_lu_c2", NORM, STALL);
      next_cycle(); expect_out("jump_lu_c3", NORM, STALL);
      next_cycle(); expect_out("jump_lu_end", NORM, NORM);

      // IRQ held, not a legal point for 4 cycles
      for (int i = 0; i < 4; i++) begin
         next_cycle(); IRQ = 1'b1; expect_out("irq_blocked", NORM, NORM);
      end
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; expect_out("irq_take", TAKE, TAKE);
      for (int i = 0; i < 2; i++) begin
         next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; expect_out("irq_service", NORM, NORM);
      end
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; Eret = 1'b1; expect_out("eret", NORM, NORM);
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; expect_out("rearm", NORM, NORM);
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; expect_out("irq_take2", TAKE, TAKE);

      // reset while in SERVICE with a stall counter loaded
      next_cycle(); load_use_r5(); expect_out("svc_lu", STALL, STALL);
      next_cycle(); reset = 1'b1; expect_out("mid_reset", RST, RST);
      next_cycle(); expect_out("post_reset", NORM, NORM);

      // one-cycle IRQ pulse never produces an ack
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; expect_out("pulse", NORM, NORM);
      for (int i = 0; i < 4; i++) begin
         next_cycle(); ID_NoIRQ = 1'b1; expect_out("pulse_gone", NORM, NORM);
      end

      // held IRQ with a legal point every cycle: ack after the IRQ latency
      for (int i = 0; i <= IRQ_LAT; i++) begin
         next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1;
         expect_out("irq_latency", (i == IRQ_LAT) ? TAKE : NORM, (i == IRQ_LAT) ? TAKE : NORM);
      end
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; expect_out("no_double_ack", NORM, NORM);

      // branch defers a pending take by one cycle
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; Eret = 1'b1; expect_out("eret2", NORM, NORM);
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; expect_out("rearm2", NORM, NORM);
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; EX_BranchTaken = 1'b1;
      expect_out("br_defers_irq", BR, BR);
      next_cycle(); IRQ = 1'b1; ID_NoIRQ = 1'b1; expect_out("deferred_take", TAKE, TAKE);
      next_cycle(); ID_NoIRQ = 1'b1; expect_out("after_deferred", NORM, NORM);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard and interrupt sequencer for the 5-stage MIPS pipeline.
- Drives the control inputs of the inter-stage registers: IF/ID source select (pass/bubble/hold), ID/EX bubble, PC hold and PC source.
- Sits beside the datapath. Consumes hazard information from ID and EX and the external interrupt line. Produces the steering signals every cycle.
- Handles multi-cycle load-use stalls, jump/branch flushes and interrupt entry/exit via a small FSM.

## Interface
Parameters:
- LOADUSE_CYCLES, default 1: number of bubble cycles inserted per load-use hazard (1..7).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- EX_MemRd  in  1  instruction in EX is a load.
- EX_Rt  in  5  load destination register in EX.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRt  in  1  instruction in ID reads Rt.
- ID_Jump  in  1  j/jal/jr/jalr decoded in ID.
- EX_BranchTaken  in  1  branch resolved taken in EX.
- ID_NoIRQ  in  1  instruction in ID is a legal interrupt point.
- IRQ  in  1  external interrupt request, level.
- Eret  in  1  handler-return pulse, decoded in ID.
- IF_ID_Src  out  2  0 pass, 1 bubble, 2 hold.
- ID_EX_Stall  out  1  insert bubble into ID/EX.
- PC_Hold  out  1  PC keeps its value.
- PC_Src  out  2  0 PC+4, 1 jump/branch target, 2 interrupt vector.
- IRQ_Ack  out  1  one-cycle pulse on interrupt entry; the datapath saves EPC.

## Operation
- Outputs are combinational from registered state plus current inputs. State updates on rising clk.
- Load-use hazard (LU) = EX_MemRd & EX_Rt≠0 & (EX_Rt==ID_Rs | (ID_UsesRt & EX_Rt==ID_Rt)).
- Stall counter cnt is 3 bits.
  - LU with cnt==0: stall this cycle and load cnt←LOADUSE_CYCLES−1.
  - cnt>0: stall this cycle and decrement.
  - Stall outputs: PC_Hold=1, IF_ID_Src=2, ID_EX_Stall=1.
- Priority per cycle, highest first:
  1. reset
  2. EX_BranchTaken
  3. IRQ take
  4. stall (LU or cnt>0)
  5. ID_Jump
  6. normal
- EX_BranchTaken:
  - Outputs: IF_ID_Src=1, ID_EX_Stall=1, PC_Src=1, PC_Hold=0.
  - cnt←0.
  - A pending IRQ take is deferred.
- ID_Jump, only when no stall is active: IF_ID_Src=1, PC_Src=1.
- Normal: IF_ID_Src=0, ID_EX_Stall=0, PC_Hold=0, PC_Src=0, IRQ_Ack=0.
- IRQ FSM states: IDLE, ARMED, SERVICE.
  - IDLE→ARMED when the effective IRQ is 1.
  - ARMED: take the interrupt when ID_NoIRQ=1, no branch taken, and cnt==0 with no LU.
    - Take cycle outputs: IRQ_Ack=1, PC_Src=2, IF_ID_Src=1, ID_EX_Stall=1.
    - Next state: SERVICE.
  - ARMED→IDLE if the effective IRQ drops before a take.
  - SERVICE: the IRQ level is ignored. Eret=1 moves to IDLE on the next edge.
  - Eret in IDLE or ARMED is ignored.

## Timing
- Reset is synchronous. While reset=1:
  - Outputs: IF_ID_Src=1, ID_EX_Stall=1, PC_Hold=1, PC_Src=0, IRQ_Ack=0.
  - On the edge: state←IDLE, cnt←0.
- A stall lasts exactly LOADUSE_CYCLES cycles, starting in the cycle LU is first seen.
- IRQ latency is 1 cycle to reach ARMED. The take happens in the first eligible cycle after that.
- IRQ_Ack is never high for 2 consecutive cycles.
- Branch and stall arriving together: the branch wins and the stall is dropped.
- Reset asserted mid-stall or in SERVICE: state is cleared at the next edge and no IRQ_Ack is issued.

## Configuration
- IRQ_SYNC_EN defined:
  - IRQ passes through a 2-flop synchronizer (reset to 0) before the FSM.
  - IDLE→ARMED latency is 3 cycles.
- IRQ_SYNC_EN undefined: IRQ feeds the FSM directly, with 1-cycle latency.

## Test plan
- LOADUSE_CYCLES=1: load to r5 in EX, ID reads Rs=5 → one cycle of IF_ID_Src=2, ID_EX_Stall=1, PC_Hold=1, then normal. Same case with EX_Rt=0 → no stall.
- LOADUSE_CYCLES=3: same hazard → exactly 3 stall cycles, even though EX_MemRd drops after the first.
- EX_BranchTaken=1 on the second stall cycle of a 3-cycle stall → that cycle gives IF_ID_Src=1, ID_EX_Stall=1, PC_Src=1, PC_Hold=0; next cycle is normal.
- IRQ=1 with ID_NoIRQ=0 for 4 cycles, then 1 → IRQ_Ack single pulse with PC_Src=2 in that cycle. IRQ held afterwards gives no second ack until an Eret pulse is seen, then a new ack follows.
- IRQ pulse of 1 cycle without IRQ_SYNC_EN → ARMED; IRQ drops before the take → IDLE, no ack. With IRQ_SYNC_EN and IRQ held → first ack no earlier than 3 cycles after assertion.
- reset=1 for 1 cycle while in SERVICE with cnt=2 → reset outputs during that cycle, then IDLE, cnt=0, normal outputs.
